// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks a registered-read byte ROM and presents
// decoded instructions (opcode plus optional one-byte operand) over a
// valid/ready handshake. A single-cycle redirect restarts fetch at a new
// address from any state.
//
// Build option: define IFU_HALT_EN to stop fetching after HALT_OPCODE is
// accepted. Without it, HALT_OPCODE is an ordinary single-byte instruction
// and the halted output is tied low.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       DATA_W      = 8,
    parameter logic [DATA_W-1:0] IMM_OPCODE  = 8'h1F,
    parameter logic [DATA_W-1:0] HALT_OPCODE = 8'h20
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_opcode,
    output logic [DATA_W-1:0] instr_operand,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              halted
);

    typedef enum logic [2:0] {
        StFetch,
        StCapture,
        StOperand,
        StIssue,
        StHalted
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_W-1:0] opcode_q, opcode_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic              halt_hit;

`ifdef IFU_HALT_EN
    assign halt_hit = (opcode_q == HALT_OPCODE);
`else
    logic unused_halt_opcode;
    assign unused_halt_opcode = ^HALT_OPCODE;
    assign halt_hit = 1'b0;
`endif

    // State register plus the pc and instruction holding registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StFetch;
            pc_q       <= '0;
            instr_pc_q <= '0;
            opcode_q   <= '0;
            operand_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            opcode_q   <= opcode_d;
            operand_q  <= operand_d;
        end
    end

    // Next-state and register updates; redirect overrides every state
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        opcode_d   = opcode_q;
        operand_d  = operand_q;
        if (redirect) begin
            state_d = StFetch;
            pc_d    = redirect_target;
        end else begin
            unique case (state_q)
                StFetch: begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StCapture;
                end
                StCapture: begin
                    // pc already points one past the opcode byte
                    opcode_d   = rom_q;
                    instr_pc_d = pc_q - ADDR_W'(1);
                    if (rom_q == IMM_OPCODE) begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = StOperand;
                    end else begin
                        operand_d = '0;
                        state_d   = StIssue;
                    end
                end
                StOperand: begin
                    operand_d = rom_q;
                    state_d   = StIssue;
                end
                StIssue: begin
                    if (instr_ready) begin
                        if (halt_hit) begin
                            state_d = StHalted;
                        end else begin
                            // ROM is already reading pc, so the next opcode
                            // arrives during CAPTURE without a FETCH cycle
                            pc_d    = pc_q + ADDR_W'(1);
                            state_d = StCapture;
                        end
                    end
                end
                StHalted: begin
                    state_d = StHalted;
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        instr_valid = (state_q == StIssue);
`ifdef IFU_HALT_EN
        halted      = (state_q == StHalted);
`else
        halted      = 1'b0;
`endif
    end

    assign rom_address   = pc_q;
    assign instr_opcode  = opcode_q;
    assign instr_operand = operand_q;
    assign instr_pc      = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed table of redirect
// targets, multi-cycle corner sequences, and a randomized run checked
// against an instruction-stream reference model.
module tb_instr_fetch_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] rom_address;
    logic [7:0] rom_q;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_operand;
    logic [7:0] instr_pc;
    logic       redirect;
    logic [7:0] redirect_target;
    logic       halted;

    logic [7:0] mem [256];
    int         checks = 0;
    int         errors = 0;

    instr_fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .rom_address     (rom_address),
        .rom_q           (rom_q),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_opcode    (instr_opcode),
        .instr_operand   (instr_operand),
        .instr_pc        (instr_pc),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halted          (halted)
    );

    always #5 clock = ~clock;

    // Registered-read ROM
    always @(posedge clock) rom_q <= mem[rom_address];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: operand byte and length of the instruction at address a
    function automatic logic [7:0] ref_operand(input logic [7:0] a);
        logic [7:0] nxt;
        nxt = a + 8'd1;
        return (mem[a] == 8'h1F) ? mem[nxt] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_next(input logic [7:0] a);
        return (mem[a] == 8'h1F) ? a + 8'd2 : a + 8'd1;
    endfunction

    // Wait (bounded) for instr_valid at a negedge and compare the issue
    task automatic expect_issue(input string name, input logic [7:0] op,
                                input logic [7:0] opnd, input logic [7:0] pc,
                                input int lat);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (instr_valid !== 1'b1 && n < 12);
        chk({name, " seen"}, instr_valid, 1'b1);
        if (instr_valid === 1'b1) begin
            if (lat > 0) chk({name, " latency"}, n, lat);
            chk({name, " issue"}, {instr_opcode, instr_operand, instr_pc}, {op, opnd, pc});
        end
    endtask

    // Called at a negedge; returns at the following negedge
    task automatic do_redirect(input logic [7:0] t);
        redirect        = 1'b1;
        redirect_target = t;
        @(negedge clock);
        redirect        = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {rom_address, instr_valid, halted, instr_opcode, instr_operand, instr_pc}, '0);
    endtask

    typedef struct {
        logic [7:0] target;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] exp_op;
        logic [7:0] exp_opnd;
        logic [7:0] exp_next;
        int         lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [7:0] exp_pc;
        logic [7:0] t;
        int         idle;
        int         issues;

        vecs[0] = '{8'h19, 8'h1F, 8'hFE, 8'h44, 8'h1F, 8'hFE, 8'h1B, 3};
        vecs[1] = '{8'hFF, 8'h1F, 8'h33, 8'h55, 8'h1F, 8'h33, 8'h01, 3};
        vecs[2] = '{8'h40, 8'h07, 8'h99, 8'h0D, 8'h07, 8'h00, 8'h41, 2};
        vecs[3] = '{8'hFF, 8'h09, 8'h1F, 8'h0C, 8'h09, 8'h00, 8'h00, 2};
        vecs[4] = '{8'h80, 8'h1F, 8'h00, 8'h2A, 8'h1F, 8'h00, 8'h82, 3};
        vecs[5] = '{8'hC0, 8'h1F, 8'h1F, 8'h11, 8'h1F, 8'h1F, 8'hC2, 3};

        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
        mem[0] = 8'h06;
        mem[1] = 8'h0B;
        reset           = 1'b1;
        instr_ready     = 1'b1;
        redirect        = 1'b0;
        redirect_target = 8'h00;

        // Reset values, then first issue on the 2nd edge after release
        @(negedge clock);
        @(negedge clock);
        check_reset_outputs("reset values");
        reset = 1'b0;
        expect_issue("first issue", 8'h06, 8'h00, 8'h00, 2);
        expect_issue("second issue", 8'h0B, 8'h00, 8'h01, 2);

        // Directed redirect table: target instruction then its successor
        for (int i = 0; i < 6; i++) begin
            t = vecs[i].target;
            mem[t] = vecs[i].b0;
            t = t + 8'd1;
            mem[t] = vecs[i].b1;
            mem[vecs[i].exp_next] = vecs[i].b2;
            do_redirect(vecs[i].target);
            expect_issue($sformatf("vec%0d", i), vecs[i].exp_op, vecs[i].exp_opnd,
                         vecs[i].target, vecs[i].lat);
            expect_issue($sformatf("vec%0d next", i), vecs[i].b2, 8'h00,
                         vecs[i].exp_next, 2);
        end

        // Back-pressure: hold ready low five cycles, then release once
        mem[8'h60] = 8'h0A;
        mem[8'h61] = 8'h0B;
        instr_ready = 1'b0;
        do_redirect(8'h60);
        expect_issue("stall issue", 8'h0A, 8'h00, 8'h60, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("stall hold %0d", i),
                {instr_valid, instr_opcode, instr_operand, instr_pc},
                {1'b1, 8'h0A, 8'h00, 8'h60});
        end
        instr_ready = 1'b1;
        expect_issue("after stall", 8'h0B, 8'h00, 8'h61, 2);

        // Redirect while the operand byte is being fetched
        mem[8'h70] = 8'h1F;
        mem[8'h71] = 8'h12;
        mem[8'h5D] = 8'h3C;
        do_redirect(8'h70);
        @(negedge clock);
        @(negedge clock);
        chk("operand phase not valid", instr_valid, 1'b0);
        do_redirect(8'h5D);
        expect_issue("redirect in operand", 8'h3C, 8'h00, 8'h5D, 2);

        // Halt opcode at 152
        mem[8'h98] = 8'h20;
        mem[8'h99] = 8'h05;
        do_redirect(8'h98);
        expect_issue("halt opcode issue", 8'h20, 8'h00, 8'h98, 2);
`ifdef IFU_HALT_EN
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk($sformatf("halted %0d", i), {halted, instr_valid, rom_address},
                {1'b1, 1'b0, 8'h99});
        end
`else
        expect_issue("after halt opcode", 8'h05, 8'h00, 8'h99, 2);
        chk("halted tied low", halted, 1'b0);
`endif

        // Randomized run against the instruction-stream model
        for (int i = 0; i < 256; i++) begin
            t = 8'($urandom);
            if (t == 8'h20) t = 8'h21;
            if ($urandom_range(0, 5) == 0) t = 8'h1F;
            mem[i] = t;
        end
        exp_pc = 8'h10;
        do_redirect(8'h10);
        idle   = 0;
        issues = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            if (instr_valid === 1'b1) begin
                chk("rand issue", {instr_opcode, instr_operand, instr_pc},
                    {mem[exp_pc], ref_operand(exp_pc), exp_pc});
                idle = 0;
            end else begin
                idle++;
            end
            chk("rand idle bound", idle <= 4, 1'b1);
            instr_ready     = ($urandom_range(0, 3) != 0);
            redirect        = ($urandom_range(0, 19) == 0);
            redirect_target = 8'($urandom);
            if (instr_valid === 1'b1 && instr_ready) begin
                exp_pc = ref_next(exp_pc);
                issues++;
            end
            if (redirect) begin
                exp_pc = redirect_target;
                idle   = 0;
            end
        end
        redirect    = 1'b0;
        instr_ready = 1'b1;
        chk("rand issue count", issues > 200, 1'b1);

        // Reset mid-stream discards the instruction in flight
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("mid reset values");
        reset = 1'b0;
        expect_issue("post reset issue", mem[0], ref_operand(8'h00), 8'h00,
                     (mem[0] == 8'h1F) ? 3 : 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
